// File: rtl/pay_pkg.sv
// Shared types and constants for the payment settlement controller.
package pay_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StSettle  = 2'd2,
    StDone    = 2'd3
  } state_e;

  localparam int unsigned COIN1_VAL  = 1;
  localparam int unsigned COIN5_VAL  = 5;
  localparam int unsigned COIN10_VAL = 10;
  localparam int unsigned COIN20_VAL = 20;
  localparam int unsigned MAX_AMOUNT = 99;

  // Value of all coin pulses seen on one edge (max 36).
  function automatic logic [5:0] coin_sum(input logic c1, input logic c5,
                                          input logic c10, input logic c20);
    logic [5:0] s;
    s = 6'd0;
    if (c1)  s = s + 6'(COIN1_VAL);
    if (c5)  s = s + 6'(COIN5_VAL);
    if (c10) s = s + 6'(COIN10_VAL);
    if (c20) s = s + 6'(COIN20_VAL);
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational 8-bit binary to two-digit BCD, saturating at 99.
module bin2bcd
  import pay_pkg::*;
(
  input  logic [7:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic [7:0] sat;

  always_comb begin
    sat    = (bin_i > 8'(MAX_AMOUNT)) ? 8'(MAX_AMOUNT) : bin_i;
    tens_o = 4'(sat / 8'd10);
    ones_o = 4'(sat % 8'd10);
  end

endmodule

// File: rtl/pay_settle.sv
// Payment settlement controller: latches a BCD price, accumulates coins, and
// reports success/failure plus BCD change to the end-of-payment display.
module pay_settle
  import pay_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TIMEOUT_S = 30,
  parameter int unsigned DONE_S    = 5
) (
  input  logic       clk,
  input  logic       EN,
  input  logic       start,
  input  logic [3:0] price_one,
  input  logic [3:0] price_ten,
  input  logic       coin1,
  input  logic       coin5,
  input  logic       coin10,
  input  logic       coin20,
  input  logic       cancel,
  input  logic       ack,
  output logic       mode,
  output logic [3:0] returnone,
  output logic [3:0] returnten,
  output logic       pay_done,
  output logic [3:0] paid_one,
  output logic [3:0] paid_ten,
  output logic       busy,
  output logic       coin_reject
);

  localparam int unsigned PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned TMAX = (TIMEOUT_S > DONE_S) ? TIMEOUT_S : DONE_S;
  localparam int unsigned SW   = $clog2(TMAX + 1);

  state_e        state_q, state_d;
  logic [6:0]    price_q, price_d;
  logic [7:0]    paid_q, paid_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          fail_q, fail_d;
  logic          mode_q, mode_d;
  logic [3:0]    ret_one_q, ret_one_d;
  logic [3:0]    ret_ten_q, ret_ten_d;
  logic          pay_done_q, pay_done_d;
  logic          coin_reject_q, coin_reject_d;

  logic [5:0]    sum;
  logic          any_coin;
  logic [7:0]    paid_sum;
  logic          price_ok;
  logic [6:0]    price_bin;
  logic          tick;
  logic [PW-1:0] presc_next;
  logic [SW-1:0] sec_next;
  logic [7:0]    chg_bin;
  logic [3:0]    chg_ten, chg_one;
  logic [3:0]    live_ten, live_one;

  bin2bcd u_chg (
    .bin_i  (chg_bin),
    .tens_o (chg_ten),
    .ones_o (chg_one)
  );

  bin2bcd u_paid (
    .bin_i  (paid_q),
    .tens_o (live_ten),
    .ones_o (live_one)
  );

  always_comb begin
    sum        = coin_sum(coin1, coin5, coin10, coin20);
    any_coin   = coin1 | coin5 | coin10 | coin20;
    paid_sum   = paid_q + {2'b00, sum};
    price_ok   = (price_ten <= 4'd9) && (price_one <= 4'd9) && ((price_ten | price_one) != 4'd0);
    price_bin  = 7'(price_ten) * 7'd10 + 7'(price_one);
    tick       = (presc_q == PW'(CLK_HZ - 1));
    presc_next = tick ? '0 : presc_q + PW'(1);
    sec_next   = tick ? sec_q + SW'(1) : sec_q;
    // Failure refunds everything paid; success returns the overpayment.
    chg_bin    = fail_q ? paid_q : paid_q - {1'b0, price_q};
  end

  always_comb begin
    state_d       = state_q;
    price_d       = price_q;
    paid_d        = paid_q;
    presc_d       = presc_q;
    sec_d         = sec_q;
    fail_d        = fail_q;
    mode_d        = mode_q;
    ret_one_d     = ret_one_q;
    ret_ten_d     = ret_ten_q;
    pay_done_d    = pay_done_q;
    coin_reject_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        coin_reject_d = any_coin;
        if (start && price_ok) begin
          state_d = StCollect;
          price_d = price_bin;
          paid_d  = '0;
          presc_d = '0;
          sec_d   = '0;
          fail_d  = 1'b0;
        end
      end
      StCollect: begin
        paid_d = paid_sum;
        if (any_coin) begin
          presc_d = '0;
          sec_d   = '0;
        end else begin
          presc_d = presc_next;
          sec_d   = sec_next;
        end
        // Coins are counted before cancel/timeout are considered.
        if (paid_sum >= {1'b0, price_q}) begin
          state_d = StSettle;
          fail_d  = 1'b0;
        end else if (cancel) begin
          state_d = StSettle;
          fail_d  = 1'b1;
        end else if (!any_coin && tick && (sec_q == SW'(TIMEOUT_S - 1))) begin
          state_d = StSettle;
          fail_d  = 1'b1;
        end
      end
      StSettle: begin
        coin_reject_d = any_coin;
        mode_d        = fail_q;
        ret_ten_d     = chg_ten;
        ret_one_d     = chg_one;
        pay_done_d    = 1'b1;
        presc_d       = '0;
        sec_d         = '0;
        state_d       = StDone;
      end
      StDone: begin
        coin_reject_d = any_coin;
        presc_d       = presc_next;
        sec_d         = sec_next;
        if (ack || (tick && (sec_q == SW'(DONE_S - 1)))) begin
          state_d    = StIdle;
          pay_done_d = 1'b0;
          ret_one_d  = 4'd0;
          ret_ten_d  = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge EN) begin
    if (!EN) begin
      state_q       <= StIdle;
      price_q       <= '0;
      paid_q        <= '0;
      presc_q       <= '0;
      sec_q         <= '0;
      fail_q        <= 1'b0;
      mode_q        <= 1'b0;
      ret_one_q     <= '0;
      ret_ten_q     <= '0;
      pay_done_q    <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      price_q       <= price_d;
      paid_q        <= paid_d;
      presc_q       <= presc_d;
      sec_q         <= sec_d;
      fail_q        <= fail_d;
      mode_q        <= mode_d;
      ret_one_q     <= ret_one_d;
      ret_ten_q     <= ret_ten_d;
      pay_done_q    <= pay_done_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  always_comb begin
    busy        = (state_q == StCollect) || (state_q == StSettle);
    paid_one    = busy ? live_one : 4'd0;
    paid_ten    = busy ? live_ten : 4'd0;
    mode        = mode_q;
    returnone   = ret_one_q;
    returnten   = ret_ten_q;
    pay_done    = pay_done_q;
    coin_reject = coin_reject_q;
  end

endmodule

// File: tb/tb_pay_settle.sv
// Self-checking bench for pay_settle: vector table, hand-written corner sequences,
// and random transactions against an amount/quiet-time model.
module tb_pay_settle;

  logic       clk = 1'b0;
  logic       EN = 1'b0;
  logic       start = 1'b0;
  logic [3:0] price_one = '0, price_ten = '0;
  logic       coin1 = 1'b0, coin5 = 1'b0, coin10 = 1'b0, coin20 = 1'b0;
  logic       cancel = 1'b0, ack = 1'b0;
  logic       mode, pay_done, busy, coin_reject;
  logic [3:0] returnone, returnten, paid_one, paid_ten;

  int checks = 0;
  int failures = 0;

  pay_settle #(
    .CLK_HZ    (10),
    .TIMEOUT_S (3),
    .DONE_S    (2)
  ) dut (
    .clk         (clk),
    .EN          (EN),
    .start       (start),
    .price_one   (price_one),
    .price_ten   (price_ten),
    .coin1       (coin1),
    .coin5       (coin5),
    .coin10      (coin10),
    .coin20      (coin20),
    .cancel      (cancel),
    .ack         (ack),
    .mode        (mode),
    .returnone   (returnone),
    .returnten   (returnten),
    .pay_done    (pay_done),
    .paid_one    (paid_one),
    .paid_ten    (paid_ten),
    .busy        (busy),
    .coin_reject (coin_reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pt;
    logic [3:0] po;
    logic [3:0] mask;   // {coin20, coin10, coin5, coin1}
    logic       cn;
    logic       valid;
    logic       emode;
    logic [3:0] eten;
    logic [3:0] eone;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] pt, input logic [3:0] po);
    price_ten = pt;
    price_one = po;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drive(input logic [3:0] mask, input logic cn);
    {coin20, coin10, coin5, coin1} = mask;
    cancel = cn;
    step();
    {coin20, coin10, coin5, coin1} = 4'b0000;
    cancel = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_exit_pay_done", pay_done, 0);
  endtask

  function automatic int mask_value(input logic [3:0] m);
    return (m[0] ? 1 : 0) + (m[1] ? 5 : 0) + (m[2] ? 10 : 0) + (m[3] ? 20 : 0);
  endfunction

  initial begin
    int n;
    vt[0] = '{4'd0, 4'd6, 4'b0011, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0};
    vt[1] = '{4'd2, 4'd5, 4'b1100, 1'b0, 1'b1, 1'b0, 4'd0, 4'd5};
    vt[2] = '{4'd3, 4'd7, 4'b0100, 1'b1, 1'b1, 1'b1, 4'd1, 4'd0};
    vt[3] = '{4'd9, 4'd9, 4'b1111, 1'b1, 1'b1, 1'b1, 4'd3, 4'd6};
    vt[4] = '{4'd0, 4'd1, 4'b0001, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    vt[5] = '{4'd1, 4'd0, 4'b1000, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0};
    vt[6] = '{4'd3, 4'd5, 4'b1111, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1};
    vt[7] = '{4'd10, 4'd3, 4'b0100, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    vt[8] = '{4'd0, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    vt[9] = '{4'd5, 4'd12, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};

    // Reset state
    #8;
    chk("rst_busy", busy, 0);
    chk("rst_pay_done", pay_done, 0);
    chk("rst_mode", mode, 0);
    chk("rst_ret", {returnten, returnone}, 0);
    chk("rst_paid", {paid_ten, paid_one}, 0);
    chk("rst_coin_reject", coin_reject, 0);
    #4 EN = 1'b1;

    // Single-edge vectors
    for (int i = 0; i < 10; i++) begin
      do_start(vt[i].pt, vt[i].po);
      if (vt[i].valid) begin
        chk("vec_busy", busy, 1);
        drive(vt[i].mask, vt[i].cn);
        chk("vec_settle_busy", busy, 1);
        step();
        chk("vec_pay_done", pay_done, 1);
        chk("vec_mode", mode, vt[i].emode);
        chk("vec_returnten", returnten, vt[i].eten);
        chk("vec_returnone", returnone, vt[i].eone);
        do_ack();
      end else begin
        chk("vec_invalid_busy", busy, 0);
        drive(vt[i].mask, 1'b0);
        chk("vec_idle_reject", coin_reject, 1);
        chk("vec_idle_paid", {paid_ten, paid_one}, 0);
        step();
        chk("vec_reject_pulse", coin_reject, 0);
      end
    end

    // 25 paid with 20 then 10; pay_done two edges after the last coin, held 20 cycles
    do_start(4'd2, 4'd5);
    drive(4'b1000, 1'b0);
    chk("s1_paid", {paid_ten, paid_one}, {4'd2, 4'd0});
    drive(4'b0100, 1'b0);
    chk("s1_settle_pay_done", pay_done, 0);
    step();
    chk("s1_pay_done", pay_done, 1);
    chk("s1_ret", {mode, returnten, returnone}, {1'b0, 4'd0, 4'd5});
    n = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (pay_done) n++;
      else break;
    end
    chk("s1_done_len", n, 20);
    chk("s1_ret_clear", {returnten, returnone}, 0);

    // 37 with 10 then cancel
    do_start(4'd3, 4'd7);
    drive(4'b0100, 1'b0);
    drive(4'b0000, 1'b1);
    chk("s2_settle_busy", busy, 1);
    step();
    chk("s2_busy_fall", busy, 0);
    chk("s2_ret", {mode, returnten, returnone}, {1'b1, 4'd1, 4'd0});
    do_ack();

    // 50, one coin5, 30 quiet cycles -> timeout
    do_start(4'd5, 4'd0);
    drive(4'b0010, 1'b0);
    for (int k = 0; k < 29; k++) step();
    chk("s3_still_collect", busy, 1);
    step();
    step();
    chk("s3_pay_done", pay_done, 1);
    chk("s3_ret", {mode, returnten, returnone}, {1'b1, 4'd0, 4'd5});
    do_ack();

    // coin1 on quiet cycle 29 restarts the timer
    do_start(4'd5, 4'd0);
    drive(4'b0010, 1'b0);
    for (int k = 0; k < 28; k++) step();
    drive(4'b0001, 1'b0);
    step();
    chk("s4_no_timeout", {busy, pay_done}, {1'b1, 1'b0});
    for (int k = 0; k < 28; k++) step();
    chk("s4_still_collect", {busy, pay_done}, {1'b1, 1'b0});
    step();
    step();
    chk("s4_ret", {pay_done, mode, returnten, returnone}, {1'b1, 1'b1, 4'd0, 4'd6});
    do_ack();

    // Reset mid-COLLECT discards progress
    do_start(4'd9, 4'd9);
    drive(4'b1000, 1'b0);
    chk("s6_paid", {paid_ten, paid_one}, {4'd2, 4'd0});
    EN = 1'b0;
    #2;
    chk("s6_rst_outputs", {busy, pay_done, mode, returnten, returnone, paid_ten, paid_one,
                           coin_reject}, 0);
    EN = 1'b1;
    step();
    chk("s6_idle", busy, 0);
    do_start(4'd9, 4'd9);
    chk("s6_restart_paid", {busy, paid_ten, paid_one}, {1'b1, 8'd0});
    drive(4'b0001, 1'b0);
    chk("s6_paid_fresh", {paid_ten, paid_one}, {4'd0, 4'd1});
    drive(4'b0000, 1'b1);
    step();
    chk("s6_ret", {mode, returnten, returnone}, {1'b1, 4'd0, 4'd1});
    do_ack();

    // Random transactions against an amount/quiet-time model
    for (int t = 0; t < 30; t++) begin
      int price, paid, quiet, cpct, chg, shown;
      logic efail, fin;
      logic [3:0] m;
      logic cn;
      price = $urandom_range(1, 99);
      cpct  = ($urandom_range(0, 3) == 0) ? 2 : 20;
      paid  = 0;
      quiet = 0;
      fin   = 1'b0;
      efail = 1'b0;
      do_start(4'(price / 10), 4'(price % 10));
      while (!fin) begin
        m  = ($urandom_range(0, 99) < cpct) ? 4'($urandom_range(1, 15)) : 4'd0;
        cn = ($urandom_range(0, 99) < 2);
        drive(m, cn);
        if (m != 0) begin
          paid += mask_value(m);
          quiet = 0;
        end else begin
          quiet++;
        end
        if (paid >= price) begin
          fin = 1'b1; efail = 1'b0;
        end else if (cn || quiet == 30) begin
          fin = 1'b1; efail = 1'b1;
        end else begin
          chk("rnd_live_paid", {paid_ten, paid_one}, {4'(paid / 10), 4'(paid % 10)});
          chk("rnd_busy", busy, 1);
        end
      end
      shown = (paid > 99) ? 99 : paid;
      chk("rnd_settle_paid", {busy, paid_ten, paid_one}, {1'b1, 4'(shown / 10), 4'(shown % 10)});
      step();
      chg = efail ? paid : paid - price;
      if (chg > 99) chg = 99;
      chk("rnd_result", {pay_done, mode, returnten, returnone},
          {1'b1, efail, 4'(chg / 10), 4'(chg % 10)});
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 19; k++) step();
        chk("rnd_done_hold", pay_done, 1);
        step();
        chk("rnd_done_expire", {pay_done, returnten, returnone}, 0);
      end else begin
        m = 4'($urandom_range(0, 15));
        {coin20, coin10, coin5, coin1} = m;
        do_ack();
        {coin20, coin10, coin5, coin1} = 4'b0000;
        chk("rnd_done_reject", coin_reject, (m != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
